mult_scheduler: RTL and testbench

MULT_SCHEDULER -- requirements
Module: mult_scheduler

---
 rtl/mult_scheduler.sv | 164 ++++++++++++++++
 tb/tb_mult_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_scheduler.sv
// mult_scheduler: one sequential shift-add Q1.(BITSIZE-1) multiplier shared
// by four requesters under a round-robin arbiter. A sticky overrun flag
// records any request left waiting across an I2S frame boundary (lrclk).
module mult_scheduler #(
    parameter int BITSIZE = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   lrclk,
    input  logic [3:0]             req,
    input  logic [4*BITSIZE-1:0]   in1,
    input  logic [4*BITSIZE-1:0]   in2,
    output logic [3:0]             ack,
    output logic [BITSIZE-1:0]     out,
    output logic                   out_valid,
    output logic [1:0]             out_id,
    output logic                   busy,
    output logic                   overrun
);

    localparam int PW = 2 * BITSIZE;
    localparam int CW = $clog2(BITSIZE);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t               state_q, state_d;
    logic [1:0]           ptr_q, ptr_d;
    logic [1:0]           owner_q, owner_d;
    logic [3:0]           ack_q, ack_d;
    logic [PW-1:0]        mcand_q, mcand_d;
    logic [BITSIZE-1:0]   mplier_q, mplier_d;
    logic [PW-1:0]        acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BITSIZE-1:0]   out_q, out_d;
    logic [1:0]           out_id_q, out_id_d;
    logic                 overrun_q, overrun_d;
    logic                 sync1_q, sync2_q, sync3_q;

    logic                 gnt_found;
    logic [1:0]           gnt_id;
    logic [3:0]           gnt_vec;
    logic [BITSIZE-1:0]   a_sel, b_sel;
    logic                 last_step;
    logic [PW-1:0]        addend, acc_sum;
    logic                 ovf;
    logic [BITSIZE-1:0]   result;
    logic                 frame_strobe;

    // Round-robin search from ptr_q upward; descending loop lets the lowest offset win.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        gnt_found = 1'b0;
        gnt_id    = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr_q + 2'(k)]) begin
                gnt_found = 1'b1;
                gnt_id    = ptr_q + 2'(k);
            end
        end
        gnt_vec = (state_q == IDLE && gnt_found) ? (4'b0001 << gnt_id) : 4'b0000;
        a_sel   = in1[int'(gnt_id)*BITSIZE +: BITSIZE];
        b_sel   = in2[int'(gnt_id)*BITSIZE +: BITSIZE];
    end

    // One multiplier bit per MUL cycle; the sign bit of B carries negative weight.
    always_comb begin
        last_step    = (cnt_q == CW'(BITSIZE - 1));
        addend       = mplier_q[0] ? (last_step ? -mcand_q : mcand_q) : '0;
        acc_sum      = acc_q + addend;
        // Only -1.0 * -1.0 reaches +1.0, which shows up as the top two bits differing.
        ovf          = acc_sum[PW-1] ^ acc_sum[PW-2];
        result       = ovf ? {1'b0, {(BITSIZE-1){1'b1}}} : acc_sum[PW-2:BITSIZE-1];
        frame_strobe = sync2_q & ~sync3_q;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        ack_d     = 4'b0000;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        out_id_d  = out_id_q;
        overrun_d = overrun_q | (frame_strobe & (|(req & ~gnt_vec)));
        unique case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    state_d  = MUL;
                    ack_d    = gnt_vec;
                    ptr_d    = gnt_id + 2'd1;
                    owner_d  = gnt_id;
                    mcand_d  = {{BITSIZE{a_sel[BITSIZE-1]}}, a_sel};
                    mplier_d = b_sel;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (last_step) begin
                    state_d  = DONE;
                    out_d    = result;
                    out_id_d = owner_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register, datapath registers and lrclk synchronizer.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!resetn) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            ack_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            out_id_q  <= '0;
            overrun_q <= 1'b0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            ack_q     <= ack_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            out_id_q  <= out_id_d;
            overrun_q <= overrun_d;
            sync1_q   <= lrclk;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
        end
    end

    // Outputs: registered values plus state decodes.
    always_comb begin
        ack       = ack_q;
        out       = out_q;
        out_id    = out_id_q;
        overrun   = overrun_q;
        busy      = (state_q != IDLE);
        out_valid = (state_q == DONE);
    end

endmodule

// File: tb/tb_mult_scheduler.sv
// Directed bench for mult_scheduler (BITSIZE = 16).
module tb_mult_scheduler;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          resetn;
    logic          lrclk;
    logic [3:0]    req;
    logic [4*W-1:0] in1, in2;
    logic [3:0]    ack;
    logic [W-1:0]  out;
    logic          out_valid;
    logic [1:0]    out_id;
    logic          busy;
    logic          overrun;

    int            n_vec = 0;
    int            n_err = 0;
    logic [W-1:0]  exp_out [4];

    mult_scheduler #(.BITSIZE(W)) dut (
        .clk(clk), .resetn(resetn), .lrclk(lrclk), .req(req),
        .in1(in1), .in2(in2), .ack(ack), .out(out), .out_valid(out_valid),
        .out_id(out_id), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] e);
        in1[id*W +: W] = a;
        in2[id*W +: W] = b;
        exp_out[id]    = e;
    endtask

    // Hold req=mask, drop each bit after its ack, expect n grants in the given order.
    task automatic arbitrate(input string name, input logic [3:0] mask, input int n,
                             input logic [7:0] order);
        int grants = 0;
        int results = 0;
        int cyc = 0;
        int last_grant = 0;
        int gt [4];
        logic [1:0] exp_id;
        logic [1:0] last_id = 2'd0;
        req = mask;
        while (results < n && cyc < 60 * n) begin
            step();
            cyc++;
            if (ack !== 4'b0000) begin
                n_vec++;
                if (grants >= n) begin
                    n_err++;
                    $display("FAIL %s extra_grant ack=%b", name, ack);
                end else begin
                    exp_id = order[2*grants +: 2];
                    if (ack !== (4'b0001 << exp_id)) begin
                        n_err++;
                        $display("FAIL %s grant%0d ack=%b expected=%b", name, grants, ack,
                                 4'b0001 << exp_id);
                    end
                    if (grants > 0) begin
                        n_vec++;
                        if (cyc - last_grant != 18) begin
                            n_err++;
                            $display("FAIL %s grant_spacing got=%0d expected=18", name,
                                     cyc - last_grant);
                        end
                    end
                    gt[grants] = cyc;
                    last_grant = cyc;
                    grants++;
                end
                req = req & ~ack;
            end
            if (out_valid === 1'b1) begin
                exp_id  = order[2*results +: 2];
                last_id = exp_id;
                n_vec += 3;
                if (out_id !== exp_id || out !== exp_out[exp_id]) begin
                    n_err++;
                    $display("FAIL %s result%0d out=%h id=%0d expected out=%h id=%0d", name,
                             results, out, out_id, exp_out[exp_id], exp_id);
                end
                if (results >= grants || cyc - gt[results] != 16) begin
                    n_err++;
                    $display("FAIL %s latency%0d got=%0d expected=16", name, results,
                             (results < grants) ? cyc - gt[results] : -1);
                end
                if (busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s busy_in_done got=%b expected=1", name, busy);
                end
                results++;
            end
        end
        if (results < n) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout results=%0d expected=%0d", name, results, n);
        end
        req = 4'b0000;
        step();
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out !== exp_out[last_id]) begin
            n_err++;
            $display("FAIL %s after_done valid=%b busy=%b out=%h expected 0 0 %h", name,
                     out_valid, busy, out, exp_out[last_id]);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step();
        step();
        n_vec++;
        if ({ack, out, out_valid, out_id, busy, overrun} !== '0) begin
            n_err++;
            $display("FAIL reset_state ack=%b out=%h v=%b id=%0d busy=%b ovr=%b expected all 0",
                     ack, out, out_valid, out_id, busy, overrun);
        end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_single();
        set_op(0, 16'h4000, 16'h4000, 16'h2000);
        arbitrate("single", 4'b0001, 1, 8'h00);
    endtask

    task automatic test_sign();
        set_op(0, 16'hFFFF, 16'h0001, 16'hFFFF);
        arbitrate("neg_floor", 4'b0001, 1, 8'h00);
        set_op(1, 16'h7FFF, 16'h8000, 16'h8001);
        arbitrate("max_x_min", 4'b0010, 1, 8'h01);
        set_op(2, 16'h8000, 16'h8000, 16'h7FFF);
        arbitrate("saturate", 4'b0100, 1, 8'h02);
    endtask

    // Last grant was to id 2, so the pointer sits at 3 and must wrap to 0.
    task automatic test_fairness();
        set_op(0, 16'h2000, 16'hC000, 16'hF000);
        set_op(2, 16'h8000, 16'h4000, 16'hC000);
        arbitrate("fairness", 4'b0101, 2, 8'b0000_1000);
    endtask

    task automatic test_reset_mid_mul();
        bit seen = 0;
        set_op(0, 16'h4000, 16'h4000, 16'h2000);
        req = 4'b0001;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (ack !== 4'b0000) seen = 1;
        end
        req = 4'b0000;
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL rst_mid ack_timeout ack=%b expected=0001", ack);
        end
        for (int i = 0; i < 4; i++) step();
        resetn = 1'b0;
        #1;
        n_vec++;
        if ({ack, out, out_valid, out_id, busy, overrun} !== '0) begin
            n_err++;
            $display("FAIL rst_mid outputs ack=%b out=%h v=%b id=%0d busy=%b ovr=%b expected all 0",
                     ack, out, out_valid, out_id, busy, overrun);
        end
        step();
        step();
        resetn = 1'b1;
        seen = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1;
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL rst_mid stale_activity got=1 expected=0");
        end
        exp_out[0] = 16'h0000;
        set_op(3, 16'hFFFF, 16'hFFFF, 16'h0000);
        arbitrate("after_reset", 4'b1000, 1, 8'h03);
    endtask

    task automatic test_contention();
        set_op(0, 16'h4000, 16'h2000, 16'h1000);
        set_op(1, 16'h4000, 16'h4000, 16'h2000);
        set_op(2, 16'h4000, 16'h6000, 16'h3000);
        set_op(3, 16'h4000, 16'h7000, 16'h3800);
        arbitrate("contention", 4'b1111, 4, 8'b11_10_01_00);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) begin
            n_vec++;
            n_err++;
            $display("FAIL %s idle_timeout busy=%b expected=0", name, busy);
        end
    endtask

    task automatic test_overrun();
        bit seen = 0;
        // Strobe lands exactly in the IDLE cycle that grants id 0.
        set_op(0, 16'h4000, 16'h4000, 16'h2000);
        step();
        lrclk = 1'b1;
        step();
        step();
        req = 4'b0001;
        step();
        n_vec++;
        if (ack !== 4'b0001) begin
            n_err++;
            $display("FAIL ovr_coincide ack=%b expected=0001", ack);
        end
        req = 4'b0000;
        for (int i = 0; i < 3; i++) step();
        n_vec++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_granted_bit overrun=%b expected=0", overrun);
        end
        wait_idle("ovr_coincide");
        lrclk = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Requester 1 waits behind a busy multiplier while a frame boundary passes.
        req = 4'b0001;
        step();
        n_vec++;
        if (ack !== 4'b0001) begin
            n_err++;
            $display("FAIL ovr_busy_grant ack=%b expected=0001", ack);
        end
        req = 4'b0000;
        step();
        step();
        set_op(1, 16'h2000, 16'h2000, 16'h0800);
        req = 4'b0010;
        step();
        lrclk = 1'b1;
        for (int i = 0; i < 4; i++) step();
        n_vec++;
        if (overrun !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_set overrun=%b expected=1", overrun);
        end
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (ack === 4'b0010) seen = 1;
        end
        req = 4'b0000;
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL ovr_waiting_grant ack=%b expected=0010", ack);
        end
        wait_idle("ovr_busy");
        lrclk = 1'b0;
        for (int i = 0; i < 4; i++) step();
        n_vec++;
        if (overrun !== 1'b1 || out !== 16'h0800 || out_id !== 2'd1) begin
            n_err++;
            $display("FAIL ovr_sticky overrun=%b out=%h id=%0d expected 1 0800 1",
                     overrun, out, out_id);
        end
    endtask

    initial begin
        resetn = 1'b0;
        lrclk  = 1'b0;
        req    = 4'b0000;
        in1    = '0;
        in2    = '0;
        for (int i = 0; i < 4; i++) exp_out[i] = '0;
        test_reset();
        test_single();
        test_sign();
        test_fairness();
        test_reset_mid_mul();
        test_contention();
        test_overrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
